// File: rtl/instr_sequencer.sv
// instr_sequencer: Moore control sequencer for the single-bus CPU datapath.
// Runs fetch (F0-F2), decodes IR[31:27], executes br/jr/jal/nop/halt and hands
// every other opcode to the execute sequencer over exec_req/exec_done.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             Con,
  input  logic             mem_ready,
  input  logic             exec_done,
  output logic [18:0]      ctrl,
  output logic             exec_req,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // ctrl bit positions
  localparam int B_PCOUT   = 0;
  localparam int B_MARIN   = 1;
  localparam int B_INCPC   = 2;
  localparam int B_ZIN     = 3;
  localparam int B_ZLOWOUT = 4;
  localparam int B_PCIN    = 5;
  localparam int B_READ    = 6;
  localparam int B_MDRIN   = 7;
  localparam int B_MDROUT  = 8;
  localparam int B_IRIN    = 9;
  localparam int B_GRA     = 10;
  localparam int B_GRB     = 11;
  localparam int B_RIN     = 12;
  localparam int B_ROUT    = 13;
  localparam int B_COUT    = 14;
  localparam int B_CONIN   = 15;
  localparam int B_YIN     = 16;
  localparam int B_ADD     = 17;
  localparam int B_R15SEL  = 18;

  // opcodes handled locally
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_BR3  = 4'd5,
    S_BR4  = 4'd6,
    S_BR5  = 4'd7,
    S_BR6  = 4'd8,
    S_JR3  = 4'd9,
    S_JL3  = 4'd10,
    S_JL4  = 4'd11,
    S_EXEC = 4'd12,
    S_HALT = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic [4:0]       opcode;

  // Only the opcode field matters here; the register fields go to the datapath.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];
  assign opcode    = IR[31:27];

  // State, sticky illegal flag and retire counter registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next-state, retire and illegal-opcode decision.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_RST:  state_d = S_F0;
      S_F0:   state_d = S_F1;
      // Stay in F1 until memory data is valid; repeating PC<-Z is harmless.
      S_F1:   if (mem_ready) state_d = S_F2;
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_BR:   state_d = S_BR3;
          OP_JR:   state_d = S_JR3;
          OP_JAL:  state_d = S_JL3;
          OP_NOP: begin
            state_d = S_F0;
            retire  = 1'b1;
          end
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
            // Undefined opcode: stop without counting it as retired.
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_BR3:  state_d = S_BR4;
      S_BR4:  state_d = S_BR5;
      S_BR5:  state_d = S_BR6;
      S_BR6: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_JR3: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_JL3:  state_d = S_JL4;
      S_JL4: begin
        state_d = S_F0;
        retire  = 1'b1;
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_F0;
          retire  = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    ctrl     = '0;
    exec_req = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_F0: begin
        ctrl[B_PCOUT] = 1'b1;
        ctrl[B_MARIN] = 1'b1;
        ctrl[B_INCPC] = 1'b1;
        ctrl[B_ZIN]   = 1'b1;
      end
      S_F1: begin
        ctrl[B_ZLOWOUT] = 1'b1;
        ctrl[B_PCIN]    = 1'b1;
        ctrl[B_READ]    = 1'b1;
        ctrl[B_MDRIN]   = 1'b1;
      end
      S_F2: begin
        ctrl[B_MDROUT] = 1'b1;
        ctrl[B_IRIN]   = 1'b1;
      end
      S_BR3: begin
        ctrl[B_GRA]   = 1'b1;
        ctrl[B_ROUT]  = 1'b1;
        ctrl[B_CONIN] = 1'b1;
      end
      S_BR4: begin
        ctrl[B_PCOUT] = 1'b1;
        ctrl[B_YIN]   = 1'b1;
      end
      S_BR5: begin
        ctrl[B_COUT] = 1'b1;
        ctrl[B_ADD]  = 1'b1;
        ctrl[B_ZIN]  = 1'b1;
      end
      S_BR6: begin
        // Con comes from the CON FF loaded in BR3, so it is already stable here.
        ctrl[B_ZLOWOUT] = 1'b1;
        ctrl[B_PCIN]    = Con;
      end
      S_JR3, S_JL4: begin
        ctrl[B_GRA]  = 1'b1;
        ctrl[B_ROUT] = 1'b1;
        ctrl[B_PCIN] = 1'b1;
      end
      S_JL3: begin
        ctrl[B_PCOUT]  = 1'b1;
        ctrl[B_RIN]    = 1'b1;
        ctrl[B_R15SEL] = 1'b1;
      end
      S_EXEC: exec_req = 1'b1;
      S_HALT: halted   = 1'b1;
      default: ctrl    = '0;
    endcase
  end

  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed stimulus with a scoreboard. Each stimulus cycle
// pushes the expected outputs of that cycle; a monitor pops and compares on the
// falling edge. A second 3-bit-counter instance shares the inputs to exercise
// the all-ones wrap of the retire counter in few cycles.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = '0;
  logic        Con = 1'b0;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;

  logic [18:0] ctrl, ctrl_w;
  logic        exec_req, halted, illegal;
  logic        exec_req_w, halted_w, illegal_w;
  logic [15:0] instr_count;
  logic [2:0]  instr_count_w;

  int tests = 0;
  int fails = 0;

  // hand-computed ctrl words
  localparam logic [18:0] C_NONE  = 19'h00000;
  localparam logic [18:0] C_F0    = 19'h0000F;
  localparam logic [18:0] C_F1    = 19'h000F0;
  localparam logic [18:0] C_F2    = 19'h00300;
  localparam logic [18:0] C_BR3   = 19'h0A400;
  localparam logic [18:0] C_BR4   = 19'h10001;
  localparam logic [18:0] C_BR5   = 19'h24008;
  localparam logic [18:0] C_BR6T  = 19'h00030;
  localparam logic [18:0] C_BR6F  = 19'h00010;
  localparam logic [18:0] C_JR3   = 19'h02420;
  localparam logic [18:0] C_JL3   = 19'h41001;
  localparam logic [18:0] C_JL4   = 19'h02420;

  localparam logic [31:0] IR_BR   = {5'b10010, 27'h0};
  localparam logic [31:0] IR_JR   = {5'b10011, 4'd3, 23'h0};
  localparam logic [31:0] IR_JAL5 = {5'b10100, 4'd5, 23'h0};
  localparam logic [31:0] IR_NOP  = {5'b11001, 27'h0};
  localparam logic [31:0] IR_HALT = {5'b11010, 27'h0};
  localparam logic [31:0] IR_ADD  = {5'b00011, 27'h0123};
  localparam logic [31:0] IR_U1B  = {5'b11011, 27'h0};
  localparam logic [31:0] IR_U1F  = {5'b11111, 27'h0};

  typedef struct packed {
    logic [18:0] ctrl;
    logic        req;
    logic        halt;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic [15:0] cnt = '0;

  instr_sequencer #(.CNT_W(16)) u_dut (
    .clock(clock), .clear(clear), .IR(IR), .Con(Con), .mem_ready(mem_ready),
    .exec_done(exec_done), .ctrl(ctrl), .exec_req(exec_req), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

  instr_sequencer #(.CNT_W(3)) u_dut_w (
    .clock(clock), .clear(clear), .IR(IR), .Con(Con), .mem_ready(mem_ready),
    .exec_done(exec_done), .ctrl(ctrl_w), .exec_req(exec_req_w), .halted(halted_w),
    .illegal(illegal_w), .instr_count(instr_count_w)
  );

  always #5 clock = ~clock;

  // Monitor: one expected record per cycle, compared away from the rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if ({ctrl, exec_req, halted, illegal, instr_count} !== {e.ctrl, e.req, e.halt, e.ill, e.cnt}) begin
        fails++;
        $display("FAIL %s: got ctrl=%05h req=%0b halt=%0b ill=%0b cnt=%04h, want ctrl=%05h req=%0b halt=%0b ill=%0b cnt=%04h",
                 n, ctrl, exec_req, halted, illegal, instr_count, e.ctrl, e.req, e.halt, e.ill, e.cnt);
      end else begin
        $display("[TB] %s ctrl=%05h req=%0b halt=%0b ill=%0b cnt=%04h ok",
                 n, ctrl, exec_req, halted, illegal, instr_count);
      end
      tests++;
      if ({ctrl_w, exec_req_w, halted_w, illegal_w, instr_count_w} !== {e.ctrl, e.req, e.halt, e.ill, e.cnt[2:0]}) begin
        fails++;
        $display("FAIL %s_w3: got ctrl=%05h req=%0b halt=%0b ill=%0b cnt=%0d, want ctrl=%05h req=%0b halt=%0b ill=%0b cnt=%0d",
                 n, ctrl_w, exec_req_w, halted_w, illegal_w, instr_count_w, e.ctrl, e.req, e.halt, e.ill, e.cnt[2:0]);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic step(input string nm, input logic [18:0] c, input logic rq,
                      input logic hl, input logic il);
    exp_t e;
    e.ctrl = c; e.req = rq; e.halt = hl; e.ill = il; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string nm);
    clear = 1'b0;
    cnt   = '0;
    step({nm, "_clr"}, C_NONE, 1'b0, 1'b0, 1'b0);
    step({nm, "_rst"}, C_NONE, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    step({nm, "_rel"}, C_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  // F0, F1 (nwait stalled cycles + 1), F2, DEC; IR is loaded for DEC.
  task automatic fetch(input string nm, input logic [31:0] ir, input int nwait, input logic stray);
    mem_ready = 1'b0;
    exec_done = stray;
    step({nm, "_F0"}, C_F0, 1'b0, 1'b0, 1'b0);
    exec_done = 1'b0;
    for (int i = 0; i < nwait; i++) step({nm, "_F1w"}, C_F1, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    step({nm, "_F1"}, C_F1, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    IR = ir;
    step({nm, "_F2"}, C_F2, 1'b0, 1'b0, 1'b0);
    step({nm, "_DEC"}, C_NONE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_br(input string nm, input logic c);
    fetch(nm, IR_BR, 0, 1'b0);
    Con = c;
    step({nm, "_BR3"}, C_BR3, 1'b0, 1'b0, 1'b0);
    step({nm, "_BR4"}, C_BR4, 1'b0, 1'b0, 1'b0);
    step({nm, "_BR5"}, C_BR5, 1'b0, 1'b0, 1'b0);
    step({nm, "_BR6"}, c ? C_BR6T : C_BR6F, 1'b0, 1'b0, 1'b0);
    cnt++;
    Con = 1'b0;
  endtask

  task automatic do_exec(input string nm, input int ncyc, input logic stray);
    fetch(nm, IR_ADD, 0, stray);
    for (int i = 0; i < ncyc; i++) begin
      exec_done = (i == ncyc - 1);
      step({nm, "_EXEC"}, C_NONE, 1'b1, 1'b0, 1'b0);
    end
    exec_done = 1'b0;
    cnt++;
  endtask

  task automatic do_nop(input string nm);
    fetch(nm, IR_NOP, 0, 1'b0);
    cnt++;
  endtask

  task automatic do_illegal(input string nm, input logic [31:0] ir);
    fetch(nm, ir, 0, 1'b0);
    exec_done = 1'b1;
    mem_ready = 1'b1;
    step({nm, "_HALT"}, C_NONE, 1'b0, 1'b1, 1'b1);
    step({nm, "_HALT"}, C_NONE, 1'b0, 1'b1, 1'b1);
    exec_done = 1'b0;
    mem_ready = 1'b0;
    do_reset(nm);
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset("init");

    fetch("nop_stall", IR_NOP, 3, 1'b0);
    cnt++;
    do_br("br_con1", 1'b1);
    do_br("br_con0", 1'b0);

    fetch("jr", IR_JR, 0, 1'b0);
    step("jr_JR3", C_JR3, 1'b0, 1'b0, 1'b0);
    cnt++;

    fetch("jal5", IR_JAL5, 0, 1'b0);
    step("jal5_JL3", C_JL3, 1'b0, 1'b0, 1'b0);
    step("jal5_JL4", C_JL4, 1'b0, 1'b0, 1'b0);
    cnt++;

    do_exec("add5", 5, 1'b1);
    do_exec("add1", 1, 1'b0);

    // Reset while the execute sequencer is busy: outputs clear before any edge.
    fetch("add_abort", IR_ADD, 0, 1'b0);
    step("add_abort_EXEC", C_NONE, 1'b1, 1'b0, 1'b0);
    step("add_abort_EXEC", C_NONE, 1'b1, 1'b0, 1'b0);
    do_reset("abort");

    fetch("halt", IR_HALT, 0, 1'b0);
    cnt++;
    exec_done = 1'b1;
    mem_ready = 1'b1;
    Con       = 1'b1;
    step("halt_HALT", C_NONE, 1'b0, 1'b1, 1'b0);
    step("halt_HALT", C_NONE, 1'b0, 1'b1, 1'b0);
    step("halt_HALT", C_NONE, 1'b0, 1'b1, 1'b0);
    exec_done = 1'b0;
    mem_ready = 1'b0;
    Con       = 1'b0;
    do_reset("halt");

    do_illegal("ill1b", IR_U1B);
    do_illegal("ill1f", IR_U1F);

    // Nine nops: the 3-bit instance passes all-ones and wraps to zero.
    for (int i = 0; i < 9; i++) do_nop("nopwrap");
    step("final_F0", C_F0, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
